trace_checker: RTL and testbench

TRACE_CHECKER -- requirements
Module: trace_checker

---
 rtl/trace_pkg.sv | 35 +++
 rtl/trace_fifo.sv | 51 +++++
 rtl/trace_checker.sv | 113 +++++++++++
 tb/tb_trace_checker.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/trace_pkg.sv
// Shared types for the commit-trace checker: FSM state, reference entry layout, wdata compare.
// Optional build macro TRACE_CHECK_BYTE_MASK_EN: compare wdata only in bytes being written.
// No timing or flow control lives here; everything is pure types and a combinational helper.
package trace_pkg;

    localparam int ENTRY_W = 32 + 5 + 32;

    typedef enum logic [1:0] {
        RUN  = 2'd0,
        PASS = 2'd1,
        FAIL = 2'd2
    } state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [4:0]  wnum;
        logic [31:0] wdata;
    } entry_t;

    function automatic logic wdata_eq(input logic [31:0] exp_d,
                                      input logic [31:0] got_d,
                                      input logic [3:0]  we);
        logic eq;
`ifdef TRACE_CHECK_BYTE_MASK_EN
        eq = 1'b1;
        for (int b = 0; b < 4; b++) begin
            if (we[b] && (exp_d[8*b +: 8] != got_d[8*b +: 8])) eq = 1'b0;
        end
`else
        eq = (exp_d == got_d) && (we == we);
`endif
        return eq;
    endfunction

endpackage

// File: rtl/trace_fifo.sv
// Synchronous FIFO of DEPTH reference entries; pointers carry an extra wrap bit for full/empty.
// Latency: push visible at head the cycle after it is accepted; pop takes effect at the clock edge.
// Backpressure: pushes are dropped while full and pops are ignored while empty.
module trace_fifo
    import trace_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int W     = ENTRY_W
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     push,
    input  logic [W-1:0]             push_dat,
    input  logic                     pop,
    output logic [W-1:0]             pop_dat,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;
    logic          push_ok;
    logic          pop_ok;

    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty   = (wr_ptr == rd_ptr);
    assign count   = wr_ptr - rd_ptr;
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign pop_dat = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage is deliberately left unreset; only the pointers define validity.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr[AW-1:0]] <= push_dat;
    end

endmodule

// File: rtl/trace_checker.sv
// Compares WB-stage register commits against a queued reference trace; sticky pass/error verdict.
// Latency: verdict, captures and match count update one cycle after the commit. Macro: TRACE_CHECK_BYTE_MASK_EN.
// Backpressure: ref_ready = !full from registered pointers; commits are never stalled.
module trace_checker
    import trace_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic [31:0]              debug_wb_pc,
    input  logic [3:0]               debug_wb_rf_we,
    input  logic [4:0]               debug_wb_rf_wnum,
    input  logic [31:0]              debug_wb_rf_wdata,
    input  logic                     ref_valid,
    output logic                     ref_ready,
    input  logic [31:0]              ref_pc,
    input  logic [4:0]               ref_wnum,
    input  logic [31:0]              ref_wdata,
    input  logic [31:0]              end_pc,
    output logic                     error,
    output logic                     pass,
    output logic [31:0]              err_pc,
    output logic [31:0]              err_exp_wdata,
    output logic [31:0]              err_got_wdata,
    output logic [31:0]              match_cnt,
    output logic [$clog2(DEPTH):0]   fifo_count
);

    state_t state_q;
    state_t state_d;
    entry_t head;
    entry_t ref_ent;
    logic   full;
    logic   empty;
    logic   push;
    logic   pop;
    logic   commit;
    logic   hit;
    logic   cnt_en;
    logic   cap_en;

    assign ref_ent   = '{pc: ref_pc, wnum: ref_wnum, wdata: ref_wdata};
    assign ref_ready = !full;
    assign push      = ref_valid && ref_ready;
    assign commit    = (|debug_wb_rf_we) && (debug_wb_rf_wnum != 5'd0);

    // Empty FIFO never hits: a same-cycle push is not forwarded to the head.
    assign hit = !empty
              && (debug_wb_pc == head.pc)
              && (debug_wb_rf_wnum == head.wnum)
              && wdata_eq(head.wdata, debug_wb_rf_wdata, debug_wb_rf_we);

    trace_fifo #(
        .DEPTH (DEPTH),
        .W     (ENTRY_W)
    ) u_fifo (
        .clk      (clk),
        .resetn   (resetn),
        .push     (push),
        .push_dat (ref_ent),
        .pop      (pop),
        .pop_dat  (head),
        .full     (full),
        .empty    (empty),
        .count    (fifo_count)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state_q <= RUN;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN: begin
                if (commit) begin
                    if (!hit)                       state_d = FAIL;
                    else if (debug_wb_pc == end_pc) state_d = PASS;
                end
            end
            PASS:    state_d = PASS;
            FAIL:    state_d = FAIL;
            default: state_d = RUN;
        endcase
    end

    always_comb begin
        pop    = (state_q == RUN) && commit;
        cnt_en = pop && hit;
        cap_en = pop && !hit;
        error  = (state_q == FAIL);
        pass   = (state_q == PASS);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            match_cnt     <= '0;
            err_pc        <= '0;
            err_exp_wdata <= '0;
            err_got_wdata <= '0;
        end else begin
            if (cnt_en && (match_cnt != 32'hFFFF_FFFF)) match_cnt <= match_cnt + 32'd1;
            if (cap_en) begin
                err_pc        <= debug_wb_pc;
                err_exp_wdata <= empty ? 32'd0 : head.wdata;
                err_got_wdata <= debug_wb_rf_wdata;
            end
        end
    end

endmodule

// File: tb/tb_trace_checker.sv
// Scoreboard bench: expected post-commit state is queued by the stimulus, a monitor compares it
// on the falling edge after every commit the DUT sees.
module tb_trace_checker;

    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        resetn;
    logic [31:0] wb_pc;
    logic [3:0]  wb_we;
    logic [4:0]  wb_wnum;
    logic [31:0] wb_wdata;
    logic        ref_valid;
    logic        ref_ready;
    logic [31:0] ref_pc;
    logic [4:0]  ref_wnum;
    logic [31:0] ref_wdata;
    logic [31:0] end_pc;
    logic        error;
    logic        pass;
    logic [31:0] err_pc;
    logic [31:0] err_exp_wdata;
    logic [31:0] err_got_wdata;
    logic [31:0] match_cnt;
    logic [$clog2(DEPTH):0] fifo_count;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        err;
        logic        pas;
        logic [31:0] mc;
        logic [31:0] epc;
        logic [31:0] eexp;
        logic [31:0] egot;
        logic [31:0] fc;
    } exp_t;

    exp_t sb[$];
    logic pend = 1'b0;

    always #5 clk = ~clk;

    trace_checker #(.DEPTH(DEPTH)) dut (
        .clk               (clk),
        .resetn            (resetn),
        .debug_wb_pc       (wb_pc),
        .debug_wb_rf_we    (wb_we),
        .debug_wb_rf_wnum  (wb_wnum),
        .debug_wb_rf_wdata (wb_wdata),
        .ref_valid         (ref_valid),
        .ref_ready         (ref_ready),
        .ref_pc            (ref_pc),
        .ref_wnum          (ref_wnum),
        .ref_wdata         (ref_wdata),
        .end_pc            (end_pc),
        .error             (error),
        .pass              (pass),
        .err_pc            (err_pc),
        .err_exp_wdata     (err_exp_wdata),
        .err_got_wdata     (err_got_wdata),
        .match_cnt         (match_cnt),
        .fifo_count        (fifo_count)
    );

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic expect_state(input logic e, input logic p, input logic [31:0] mc,
                                input logic [31:0] epc, input logic [31:0] eexp,
                                input logic [31:0] egot, input logic [31:0] fc);
        exp_t x;
        x.err = e; x.pas = p; x.mc = mc; x.epc = epc; x.eexp = eexp; x.egot = egot; x.fc = fc;
        sb.push_back(x);
    endtask

    // Monitor: a commit sampled at a rising edge produces an output to check at the next falling edge.
    always @(posedge clk) pend <= resetn && (|wb_we) && (wb_wnum != 5'd0);

    always @(negedge clk) begin
        if (pend) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL scoreboard: commit output seen with no expected entry at %0t", $time);
            end else begin
                exp_t x;
                x = sb.pop_front();
                chk("error",         {31'd0, error},  {31'd0, x.err});
                chk("pass",          {31'd0, pass},   {31'd0, x.pas});
                chk("match_cnt",     match_cnt,       x.mc);
                chk("err_pc",        err_pc,          x.epc);
                chk("err_exp_wdata", err_exp_wdata,   x.eexp);
                chk("err_got_wdata", err_got_wdata,   x.egot);
                chk("fifo_count",    32'(fifo_count), x.fc);
            end
        end
    end

    task automatic idle_inputs();
        wb_pc = '0; wb_we = '0; wb_wnum = '0; wb_wdata = '0;
        ref_valid = 1'b0; ref_pc = '0; ref_wnum = '0; ref_wdata = '0;
    endtask

    // One cycle of stimulus, entered and left on a falling edge.
    task automatic step(input logic [3:0] we, input logic [4:0] wn, input logic [31:0] pc,
                        input logic [31:0] wd, input logic pv, input logic [31:0] rpc,
                        input logic [4:0] rwn, input logic [31:0] rwd);
        wb_we = we; wb_wnum = wn; wb_pc = pc; wb_wdata = wd;
        ref_valid = pv; ref_pc = rpc; ref_wnum = rwn; ref_wdata = rwd;
        @(negedge clk);
        idle_inputs();
    endtask

    task automatic push(input logic [31:0] pc, input logic [4:0] wn, input logic [31:0] wd);
        step(4'h0, 5'd0, 32'd0, 32'd0, 1'b1, pc, wn, wd);
    endtask

    task automatic commit(input logic [3:0] we, input logic [4:0] wn, input logic [31:0] pc,
                          input logic [31:0] wd);
        step(we, wn, pc, wd, 1'b0, 32'd0, 5'd0, 32'd0);
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
    endtask

    function automatic logic [31:0] e_pc(input int i);  return 32'h1c00_1000 + 32'(i) * 4; endfunction
    function automatic logic [4:0]  e_wn(input int i);  return 5'((i % 31) + 1);           endfunction
    function automatic logic [31:0] e_wd(input int i);  return 32'h100 + 32'(i);           endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        idle_inputs();
        end_pc = 32'h1c00_0008;
        resetn = 1'b0;
        #1;
        chk("reset error",      {31'd0, error},     32'd0);
        chk("reset pass",       {31'd0, pass},      32'd0);
        chk("reset ref_ready",  {31'd0, ref_ready}, 32'd1);
        chk("reset fifo_count", 32'(fifo_count),    32'd0);
        chk("reset match_cnt",  match_cnt,          32'd0);
        @(negedge clk);
        resetn = 1'b1;

        // Three matching commits, the last at end_pc.
        push(32'h1c00_0000, 5'd4, 32'h11);
        push(32'h1c00_0004, 5'd5, 32'h22);
        push(32'h1c00_0008, 5'd6, 32'h33);
        expect_state(0, 0, 1, 0, 0, 0, 2);
        commit(4'hF, 5'd4, 32'h1c00_0000, 32'h11);
        expect_state(0, 0, 2, 0, 0, 0, 1);
        commit(4'hF, 5'd5, 32'h1c00_0004, 32'h22);
        expect_state(0, 1, 3, 0, 0, 0, 0);
        commit(4'hF, 5'd6, 32'h1c00_0008, 32'h33);
        expect_state(0, 1, 3, 0, 0, 0, 0);
        commit(4'hF, 5'd7, 32'h1c00_000c, 32'h44);
        do_reset();

        // Data mismatch, then frozen state while pushes are still accepted.
        push(32'h1c00_0000, 5'd4, 32'h11);
        expect_state(1, 0, 0, 32'h1c00_0000, 32'h11, 32'h12, 0);
        commit(4'hF, 5'd4, 32'h1c00_0000, 32'h12);
        push(32'h1c00_0004, 5'd5, 32'h22);
        expect_state(1, 0, 0, 32'h1c00_0000, 32'h11, 32'h12, 1);
        commit(4'hF, 5'd5, 32'h1c00_0004, 32'h22);
        do_reset();

        // Underflow with a same-cycle push: no bypass, entry still stored.
        expect_state(1, 0, 0, 32'h1c00_0100, 32'h0, 32'h55, 1);
        step(4'hF, 5'd3, 32'h1c00_0100, 32'h55, 1'b1, 32'h1c00_0200, 5'd7, 32'h77);
        do_reset();

        // Writes to r0 and with no byte enables are not commits.
        end_pc = 32'h0;
        push(32'h1c00_0000, 5'd1, 32'hA);
        commit(4'hF, 5'd0, 32'h1c00_0000, 32'hA);
        chk("r0 write fifo_count", 32'(fifo_count), 32'd1);
        chk("r0 write match_cnt",  match_cnt,       32'd0);
        commit(4'h0, 5'd1, 32'h1c00_0000, 32'hA);
        chk("we=0 fifo_count",     32'(fifo_count), 32'd1);
        expect_state(0, 0, 1, 0, 0, 0, 0);
        commit(4'hF, 5'd1, 32'h1c00_0000, 32'hA);

        // Asynchronous reset with 5 entries queued, checked before any clock edge.
        for (int i = 0; i < 5; i++) push(e_pc(i), e_wn(i), e_wd(i));
        chk("queued fifo_count", 32'(fifo_count), 32'd5);
        #2;
        resetn = 1'b0;
        #1;
        chk("async rst fifo_count", 32'(fifo_count),    32'd0);
        chk("async rst error",      {31'd0, error},     32'd0);
        chk("async rst ref_ready",  {31'd0, ref_ready}, 32'd1);
        chk("async rst match_cnt",  match_cnt,          32'd0);
        @(negedge clk);
        resetn = 1'b1;

        // Fill, refused push on full with same-cycle pop, then wrap twice.
        for (int i = 0; i < DEPTH; i++) push(e_pc(i), e_wn(i), e_wd(i));
        chk("full ref_ready",  {31'd0, ref_ready}, 32'd0);
        chk("full fifo_count", 32'(fifo_count),    32'd8);
        expect_state(0, 0, 1, 0, 0, 0, 7);
        step(4'hF, e_wn(0), e_pc(0), e_wd(0), 1'b1, 32'hdead_beef, 5'd9, 32'hbad);
        chk("after refused push ref_ready", {31'd0, ref_ready}, 32'd1);
        for (int k = 0; k < 9; k++) begin
            expect_state(0, 0, 32'(2 + k), 0, 0, 0, 7);
            step(4'hF, e_wn(1 + k), e_pc(1 + k), e_wd(1 + k),
                 1'b1, e_pc(8 + k), e_wn(8 + k), e_wd(8 + k));
        end
        for (int j = 0; j < 7; j++) begin
            expect_state(0, 0, 32'(11 + j), 0, 0, 0, 32'(6 - j));
            commit(4'hF, e_wn(10 + j), e_pc(10 + j), e_wd(10 + j));
        end
        do_reset();

        // Partial-byte write: upper bytes differ from the reference.
        push(32'h1c00_0300, 5'd9, 32'h0000_0011);
`ifdef TRACE_CHECK_BYTE_MASK_EN
        expect_state(0, 0, 1, 0, 0, 0, 0);
`else
        expect_state(1, 0, 0, 32'h1c00_0300, 32'h0000_0011, 32'hAB00_0011, 0);
`endif
        commit(4'b0001, 5'd9, 32'h1c00_0300, 32'hAB00_0011);

        @(negedge clk);
        @(negedge clk);
        chk("scoreboard drained", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
